// File: rtl/addr_gen_unit_if.sv
// Request/response and shared read-bus signals of the 6502 effective-address generator.
// The master side issues requests and serves reads; the slave side is the generator.
interface addr_gen_unit_if #(
    parameter int DATA_W = 8
);
    localparam int ADDR_W = 2 * DATA_W;

    logic              start;
    logic [3:0]        mode;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] x_in;
    logic [DATA_W-1:0] y_in;
    logic [DATA_W-1:0] data_read;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ea;
    logic              page_cross;
    logic [1:0]        operand_len;
    logic              err;

    modport master (
        output start, mode, pc, x_in, y_in, data_read,
        input  mem_addr, mem_req, busy, done, ea, page_cross, operand_len, err
    );

    modport slave (
        input  start, mode, pc, x_in, y_in, data_read,
        output mem_addr, mem_req, busy, done, ea, page_cross, operand_len, err
    );
endinterface

// File: rtl/addr_gen_unit.sv
// Sequenced 6502 effective-address generator: fetches operand and pointer bytes over
// the shared read bus and returns the effective address, page-cross flag and operand length.
module addr_gen_unit #(
    parameter int DATA_W       = 8,
    parameter int PAGE_PENALTY = 1,
    parameter int JMP_IND_BUG  = 1
) (
    input logic            clk,
    input logic            rst,
    addr_gen_unit_if.slave bus
);
    localparam int ADDR_W = 2 * DATA_W;
    localparam logic [DATA_W-1:0] ZERO_PAGE = '0;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_LO, S_FETCH_HI, S_PTR_LO, S_PTR_HI, S_FIX, S_DONE
    } state_t;

    typedef enum logic [3:0] {
        M_IMM, M_ZP, M_ZPX, M_ZPY, M_ABS, M_ABSX, M_ABSY, M_IND, M_INDX, M_INDY
    } mode_t;

    state_t            state, state_nxt;
    mode_t             mode_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] x_q, y_q, lo_q, hi_q, pl_q;
    logic [ADDR_W-1:0] ea_q;
    logic              page_cross_q;
    logic [1:0]        len_q;
    logic              err_q;

    logic              accept;
    logic              mode_ok;
    logic [DATA_W-1:0] idx;
    logic [DATA_W:0]   abs_sum;
    logic [DATA_W:0]   ptr_sum;
    logic [DATA_W-1:0] zp_lo;
    logic [DATA_W-1:0] lo_inc;
    logic [DATA_W-1:0] zp_ptr;
    logic [DATA_W-1:0] zp_ptr_inc;
    logic [ADDR_W-1:0] mem_addr;

    function automatic logic [1:0] len_of(input logic [3:0] m);
        case (m)
            M_IMM, M_ZP, M_ZPX, M_ZPY, M_INDX, M_INDY: len_of = 2'd1;
            M_ABS, M_ABSX, M_ABSY, M_IND:              len_of = 2'd2;
            default:                                   len_of = 2'd0;
        endcase
    endfunction

    assign accept  = bus.start && (state == S_IDLE || state == S_DONE);
    assign mode_ok = (bus.mode <= M_INDY);

    always_comb begin
        case (mode_q)
            M_ZPX, M_ABSX:         idx = x_q;
            M_ZPY, M_ABSY, M_INDY: idx = y_q;
            default:               idx = '0;
        endcase
    end

    // Low-byte sums keep the carry bit so the high byte and page_cross can use it.
    assign abs_sum    = {1'b0, lo_q} + {1'b0, idx};
    assign ptr_sum    = {1'b0, pl_q} + {1'b0, y_q};
    assign zp_lo      = bus.data_read + idx;
    assign lo_inc     = lo_q + DATA_W'(1);
    assign zp_ptr     = lo_q + x_q;
    assign zp_ptr_inc = zp_ptr + DATA_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output is given a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (!mode_ok || bus.mode == M_IMM) state_nxt = S_DONE;
                    else                               state_nxt = S_FETCH_LO;
                end else if (state == S_DONE) begin
                    state_nxt = S_IDLE;
                end
            end
            S_FETCH_LO: begin
                case (mode_q)
                    M_ZP, M_ZPX, M_ZPY: state_nxt = S_DONE;
                    M_INDX, M_INDY:     state_nxt = S_PTR_LO;
                    default:            state_nxt = S_FETCH_HI;
                endcase
            end
            S_FETCH_HI: begin
                case (mode_q)
                    M_ABSX, M_ABSY: state_nxt = (abs_sum[DATA_W] && PAGE_PENALTY != 0) ? S_FIX : S_DONE;
                    M_IND:          state_nxt = S_PTR_LO;
                    default:        state_nxt = S_DONE;
                endcase
            end
            S_PTR_LO: state_nxt = S_PTR_HI;
            S_PTR_HI: begin
                if (mode_q == M_INDY && ptr_sum[DATA_W] && PAGE_PENALTY != 0) state_nxt = S_FIX;
                else                                                           state_nxt = S_DONE;
            end
            S_FIX:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr = '0;
        case (state)
            S_FETCH_LO: mem_addr = pc_q;
            S_FETCH_HI: mem_addr = pc_q + ADDR_W'(1);
            S_PTR_LO: begin
                case (mode_q)
                    M_IND:   mem_addr = {hi_q, lo_q};
                    M_INDX:  mem_addr = {ZERO_PAGE, zp_ptr};
                    default: mem_addr = {ZERO_PAGE, lo_q};
                endcase
            end
            S_PTR_HI: begin
                case (mode_q)
                    // The original JMP (ind) never carries into the pointer's high byte.
                    M_IND:   mem_addr = (JMP_IND_BUG != 0) ? {hi_q, lo_inc} : {hi_q, lo_q} + ADDR_W'(1);
                    M_INDX:  mem_addr = {ZERO_PAGE, zp_ptr_inc};
                    default: mem_addr = {ZERO_PAGE, lo_inc};
                endcase
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= M_IMM;
            pc_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            pl_q         <= '0;
            ea_q         <= '0;
            page_cross_q <= 1'b0;
            len_q        <= 2'd0;
            err_q        <= 1'b0;
        end else if (accept) begin
            mode_q       <= mode_t'(bus.mode);
            pc_q         <= bus.pc;
            x_q          <= bus.x_in;
            y_q          <= bus.y_in;
            page_cross_q <= 1'b0;
            err_q        <= !mode_ok;
            len_q        <= len_of(bus.mode);
            ea_q         <= (bus.mode == M_IMM) ? bus.pc : '0;
        end else begin
            case (state)
                S_FETCH_LO: begin
                    lo_q <= bus.data_read;
                    if (mode_q == M_ZP || mode_q == M_ZPX || mode_q == M_ZPY)
                        ea_q <= {ZERO_PAGE, zp_lo};
                end
                S_FETCH_HI: begin
                    hi_q <= bus.data_read;
                    if (mode_q == M_ABS) begin
                        ea_q <= {bus.data_read, lo_q};
                    end else if (mode_q == M_ABSX || mode_q == M_ABSY) begin
                        ea_q         <= {bus.data_read + DATA_W'(abs_sum[DATA_W]), abs_sum[DATA_W-1:0]};
                        page_cross_q <= abs_sum[DATA_W];
                    end
                end
                S_PTR_LO: pl_q <= bus.data_read;
                S_PTR_HI: begin
                    if (mode_q == M_INDY) begin
                        ea_q         <= {bus.data_read + DATA_W'(ptr_sum[DATA_W]), ptr_sum[DATA_W-1:0]};
                        page_cross_q <= ptr_sum[DATA_W];
                    end else begin
                        ea_q <= {bus.data_read, pl_q};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr    = mem_addr;
    assign bus.mem_req     = (state == S_FETCH_LO) || (state == S_FETCH_HI) ||
                             (state == S_PTR_LO)   || (state == S_PTR_HI);
    assign bus.busy        = (state != S_IDLE) && (state != S_DONE);
    assign bus.done        = (state == S_DONE);
    assign bus.ea          = ea_q;
    assign bus.page_cross  = page_cross_q;
    assign bus.operand_len = len_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_addr_gen_unit.sv
// Scoreboard bench for addr_gen_unit: two instances (penalty+bug, and neither) share stimulus
// and memory; expected results are queued at issue and checked whenever done is seen.
module tb_addr_gen_unit;
    localparam int DATA_W = 8;

    typedef struct {
        logic [15:0] ea;
        logic        pcross;
        logic [1:0]  len;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  mode;
    logic [15:0] pc;
    logic [7:0]  x, y;
    logic [7:0]  mem [0:65535];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          req_cnt = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        e_a, e_b;
    logic [15:0] trace[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addr_gen_unit_if #(.DATA_W(DATA_W)) bus_a ();
    addr_gen_unit_if #(.DATA_W(DATA_W)) bus_b ();

    assign bus_a.start = start;  assign bus_b.start = start;
    assign bus_a.mode  = mode;   assign bus_b.mode  = mode;
    assign bus_a.pc    = pc;     assign bus_b.pc    = pc;
    assign bus_a.x_in  = x;      assign bus_b.x_in  = x;
    assign bus_a.y_in  = y;      assign bus_b.y_in  = y;
    assign bus_a.data_read = mem[bus_a.mem_addr];
    assign bus_b.data_read = mem[bus_b.mem_addr];

    addr_gen_unit #(.DATA_W(DATA_W), .PAGE_PENALTY(1), .JMP_IND_BUG(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a));
    addr_gen_unit #(.DATA_W(DATA_W), .PAGE_PENALTY(0), .JMP_IND_BUG(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.mem_req) begin
                req_cnt++;
                trace.push_back(bus_a.mem_addr);
            end
            if (bus_a.done) begin
                if (q_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
                end else begin
                    e_a = q_a.pop_front();
                    check("a_ea", bus_a.ea, e_a.ea);
                    check("a_page_cross", bus_a.page_cross, e_a.pcross);
                    check("a_operand_len", bus_a.operand_len, e_a.len);
                    check("a_err", bus_a.err, e_a.err);
                    check("a_done_cycle", cyc, e_a.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus_b.done) begin
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
            end else begin
                e_b = q_b.pop_front();
                check("b_ea", bus_b.ea, e_b.ea);
                check("b_page_cross", bus_b.page_cross, e_b.pcross);
                check("b_operand_len", bus_b.operand_len, e_b.len);
                check("b_err", bus_b.err, e_b.err);
                check("b_done_cycle", cyc, e_b.cyc);
            end
        end
    end

    // Called just after a negedge; scrambles the request inputs once the accept edge has passed.
    task automatic issue(input logic [3:0] m, input logic [15:0] p, input logic [7:0] xi, input logic [7:0] yi,
                         input logic [15:0] ea_a, input logic [15:0] ea_b, input logic pc_a, input logic pc_b,
                         input logic [1:0] len, input logic er, input int lat_a, input int lat_b);
        mode = m; pc = p; x = xi; y = yi; start = 1'b1;
        q_a.push_back('{ea: ea_a, pcross: pc_a, len: len, err: er, cyc: cyc + lat_a});
        q_b.push_back('{ea: ea_b, pcross: pc_b, len: len, err: er, cyc: cyc + lat_b});
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 4'($urandom);
        pc    = 16'($urandom);
        x     = 8'($urandom);
        y     = 8'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (q_a.size() == 0 && q_b.size() == 0) break;
        end
        if (q_a.size() != 0 || q_b.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout: got %0d/%0d results pending expected 0", q_a.size(), q_b.size());
            q_a.delete();
            q_b.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_done"},        bus_a.done,        0);
        check({tag, "_busy"},        bus_a.busy,        0);
        check({tag, "_mem_req"},     bus_a.mem_req,     0);
        check({tag, "_mem_addr"},    bus_a.mem_addr,    0);
        check({tag, "_ea"},          bus_a.ea,          0);
        check({tag, "_page_cross"},  bus_a.page_cross,  0);
        check({tag, "_operand_len"}, bus_a.operand_len, 0);
        check({tag, "_err"},         bus_a.err,         0);
        check({tag, "_b_busy"},      bus_b.busy,        0);
        check({tag, "_b_mem_addr"},  bus_b.mem_addr,    0);
    endtask

    int req0;

    initial begin
        rst = 1'b1; start = 1'b0; mode = '0; pc = '0; x = '0; y = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEE;
        mem[16'h0200] = 8'h44;
        mem[16'h0300] = 8'hF0;
        mem[16'h0310] = 8'h80;
        mem[16'h0400] = 8'h34; mem[16'h0401] = 8'h12;
        mem[16'h0410] = 8'h10; mem[16'h0411] = 8'h20;
        mem[16'h0420] = 8'hFF; mem[16'h0421] = 8'h12;
        mem[16'h0500] = 8'hFF; mem[16'h0501] = 8'h30;
        mem[16'h30FF] = 8'h80; mem[16'h3000] = 8'h50; mem[16'h3100] = 8'h60;
        mem[16'h0600] = 8'hFE;
        mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
        mem[16'h0700] = 8'h40; mem[16'h0040] = 8'hF0; mem[16'h0041] = 8'h22;
        mem[16'h0710] = 8'h42; mem[16'h0042] = 8'h10; mem[16'h0043] = 8'h33;
        mem[16'h0720] = 8'hFF;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk); #1;

        //    mode   pc        x      y      ea_a      ea_b      pca   pcb   len err la lb
        issue(4'd0,  16'h1234, 8'h00, 8'h00, 16'h1234, 16'h1234, 1'b0, 1'b0, 1, 0, 1, 1); wait_idle();

        req0 = req_cnt;
        issue(4'd12, 16'h0800, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 1, 1, 1); wait_idle();
        check("illegal_mem_req_cycles", req_cnt - req0, 0);

        issue(4'd1,  16'h0200, 8'h11, 8'h22, 16'h0044, 16'h0044, 1'b0, 1'b0, 1, 0, 2, 2); wait_idle();
        issue(4'd2,  16'h0300, 8'h20, 8'h00, 16'h0010, 16'h0010, 1'b0, 1'b0, 1, 0, 2, 2); wait_idle();
        issue(4'd3,  16'h0310, 8'hAA, 8'h05, 16'h0085, 16'h0085, 1'b0, 1'b0, 1, 0, 2, 2); wait_idle();
        issue(4'd4,  16'h0400, 8'h00, 8'h00, 16'h1234, 16'h1234, 1'b0, 1'b0, 2, 0, 3, 3); wait_idle();
        issue(4'd5,  16'h0410, 8'h05, 8'hFF, 16'h2015, 16'h2015, 1'b0, 1'b0, 2, 0, 3, 3); wait_idle();
        issue(4'd6,  16'h0420, 8'h00, 8'h01, 16'h1300, 16'h1300, 1'b1, 1'b1, 2, 0, 4, 3); wait_idle();
        issue(4'd7,  16'h0500, 8'h00, 8'h00, 16'h5080, 16'h6080, 1'b0, 1'b0, 2, 0, 5, 5); wait_idle();

        trace.delete();
        issue(4'd8,  16'h0600, 8'h01, 8'h00, 16'h1234, 16'h1234, 1'b0, 1'b0, 1, 0, 4, 4); wait_idle();
        check("indx_trace_len", trace.size(), 3);
        if (trace.size() == 3) begin
            check("indx_addr0", trace[0], 16'h0600);
            check("indx_addr1", trace[1], 16'h00FF);
            check("indx_addr2", trace[2], 16'h0000);
        end

        issue(4'd9,  16'h0700, 8'h00, 8'h20, 16'h2310, 16'h2310, 1'b1, 1'b1, 1, 0, 5, 4); wait_idle();
        issue(4'd9,  16'h0710, 8'h00, 8'h01, 16'h3311, 16'h3311, 1'b0, 1'b0, 1, 0, 4, 4); wait_idle();
        issue(4'd9,  16'h0720, 8'h00, 8'h00, 16'h1234, 16'h1234, 1'b0, 1'b0, 1, 0, 4, 4); wait_idle();

        // A start while busy must be dropped: only the ABS result may appear.
        issue(4'd4,  16'h0400, 8'h00, 8'h00, 16'h1234, 16'h1234, 1'b0, 1'b0, 2, 0, 3, 3);
        mode = 4'd0; pc = 16'hBEEF; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        #1;

        // A start sampled in DONE is accepted back-to-back.
        issue(4'd4,  16'h0400, 8'h00, 8'h00, 16'h1234, 16'h1234, 1'b0, 1'b0, 2, 0, 3, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (bus_a.done) break;
        end
        check("b2b_in_done", bus_a.done, 1);
        issue(4'd1,  16'h0200, 8'h00, 8'h00, 16'h0044, 16'h0044, 1'b0, 1'b0, 1, 0, 2, 2); wait_idle();

        // Asynchronous reset in cycle 3 of an IND operation; the result must never appear.
        issue(4'd7,  16'h0500, 8'h00, 8'h00, 16'h5080, 16'h6080, 1'b0, 1'b0, 2, 0, 5, 5);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_ind_busy", bus_a.busy, 1);
        check("mid_ind_mem_addr", bus_a.mem_addr, 16'h30FF);
        #1;
        q_a.delete();
        q_b.delete();
        rst = 1'b1;
        #1;
        check_zero("abort");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;

        issue(4'd0,  16'h4321, 8'h00, 8'h00, 16'h4321, 16'h4321, 1'b0, 1'b0, 1, 0, 1, 1); wait_idle();

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/addr_gen_unit.md
# addr_gen_unit

Parametrised effective-address generator for the 6502 datapath; it replaces the two-way PC/zero-page address select with a sequenced unit covering all ten operand addressing modes. It takes `start`, the mode, the operand PC and the index registers. It then fetches operand and pointer bytes over the shared read bus and returns the effective address, the page-cross status and the operand length. The control unit advances PC by `operand_len` and charges the extra cycle when `page_cross` is set.

## Interface
- `DATA_W`, 8: byte width; `ADDR_W` = 2*`DATA_W` is fixed.
- `PAGE_PENALTY`, 1: 1 inserts a FIX cycle on an indexed page cross; 0 never does.
- `JMP_IND_BUG`, 1: 1 makes the indirect high-byte fetch wrap within the pointer's page; 0 uses a full carry.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; accepted only in IDLE or DONE.
- `mode` in 4: 0 IMM, 1 ZP, 2 ZPX, 3 ZPY, 4 ABS, 5 ABSX, 6 ABSY, 7 IND, 8 INDX, 9 INDY; 10–15 are illegal.
- `pc` in ADDR_W: address of the first operand byte.
- `x_in`, `y_in` in DATA_W: index values.
- `data_read` in DATA_W: read data for `mem_addr`, combinational in the same cycle.
- `mem_addr` out ADDR_W: fetch address.
- `mem_req` out 1: high while the unit owns the bus.
- `busy` out 1: high while state is neither IDLE nor DONE.
- `done` out 1: one-cycle result pulse.
- `ea` out ADDR_W: effective address, held until the next accept.
- `page_cross` out 1: high-byte change caused by indexing.
- `operand_len` out 2: operand bytes consumed.
- `err` out 1: illegal mode, reported with `done`.

## Operation
- States: IDLE, FETCH_LO, FETCH_HI, PTR_LO, PTR_HI, FIX, DONE.
- On accept, latch `mode`, `pc`, `x_in` and `y_in`; later input changes are ignored. Clear `page_cross` and `err`.
- IMM: IDLE→DONE; `ea`=`pc`, no fetch.
- FETCH_LO: `mem_addr`=`pc`; capture `lo`.
  - ZP, ZPX, ZPY: `ea`={0, `lo`+idx mod 2^DATA_W}, then →DONE.
  - INDX, INDY: →PTR_LO.
  - Otherwise →FETCH_HI.
- FETCH_HI: `mem_addr`=`pc`+1 (full ADDR_W add); capture `hi`.
  - ABS: `ea`={`hi`,`lo`}.
  - ABSX, ABSY: `ea`={`hi`,`lo`}+idx; `page_cross`=carry out of the low byte. Go →FIX if `page_cross`&`PAGE_PENALTY`, else →DONE.
  - IND: →PTR_LO.
- PTR_LO reads the pointer low byte `pl` at:
  - IND: {`hi`,`lo`}.
  - INDX: {0,`lo`+x}.
  - INDY: {0,`lo`}.
- PTR_HI reads the pointer high byte `ph` at:
  - IND with `JMP_IND_BUG`=1: {`hi`,`lo`+1 mod 2^DATA_W}.
  - IND with `JMP_IND_BUG`=0: {`hi`,`lo`}+1.
  - INDX: {0,`lo`+x+1}, wrapping in page 0.
  - INDY: {0,`lo`+1}, wrapping in page 0.
- PTR_HI results:
  - IND, INDX: `ea`={`ph`,`pl`}.
  - INDY: `ea`={`ph`,`pl`}+y, with `page_cross` and FIX as for ABSY.
- FIX: 1 idle cycle with `mem_req`=0, then →DONE.
- Illegal mode: IDLE→DONE with `err`=1 and `ea`=0.
- DONE: `done`=1 for exactly one cycle, then →IDLE. A `start` sampled in DONE is accepted, giving back-to-back operation.
- `operand_len` (valid with `done`): IMM, ZP\*, INDX and INDY give 1; ABS\* and IND give 2; illegal gives 0.
- `mem_req`=1 only in FETCH_LO, FETCH_HI, PTR_LO and PTR_HI. `mem_addr`=0 otherwise.

## Timing
- Reset (asynchronous, at any time, including mid-operation) forces:
  - state IDLE;
  - `done`, `busy`, `mem_req`, `page_cross` and `err` all 0;
  - `ea`, `mem_addr` and `operand_len` all 0.
  - An aborted operation never produces `done`.
- Latency counts cycles from the accepting edge to the cycle in which `done` is high:
  - IMM and illegal: 1.
  - ZP, ZPX, ZPY: 2.
  - ABS, ABSX, ABSY: 3, plus 1 on a penalised cross.
  - INDX: 4.
  - INDY: 4, plus 1 on a penalised cross.
  - IND: 5.
- A `start` while `busy`=1 is ignored, with no queuing.
- `ea`, `page_cross`, `operand_len` and `err` are registered. They are stable from `done` until the next accept.

## Test plan
- ZPX wrap: `lo`=0xF0, X=0x20 → `ea`=0x0010, `done` at cycle 2, `operand_len`=1, `page_cross`=0.
- ABSY cross: bytes 0xFF, 0x12, Y=0x01.
  - `PAGE_PENALTY`=1 → `ea`=0x1300, `page_cross`=1, `done` at cycle 4.
  - `PAGE_PENALTY`=0 → `done` at cycle 3.
- IND page bug: operand 0x30FF, mem[0x30FF]=0x80, mem[0x3000]=0x50, mem[0x3100]=0x60.
  - `JMP_IND_BUG`=1 → `ea`=0x5080.
  - `JMP_IND_BUG`=0 → `ea`=0x6080.
  - `done` at cycle 5 in both cases.
- INDX zero-page wrap: `lo`=0xFE, X=0x01, mem[0x00FF]=0x34, mem[0x0000]=0x12 → `mem_addr` sequence `pc`, 0x00FF, 0x0000; `ea`=0x1234.
- Reset mid-IND at cycle 3 → all outputs 0 the same cycle, no `done`. Also: a `start` during `busy` is ignored, and a `start` in DONE is accepted, giving ZP `done` 2 cycles later.
- `mode`=12 → `done` at cycle 1, `err`=1, `ea`=0, `mem_req` never asserted.
